// File: rtl/gpio_cap_pkg.sv
// Shared types for the GPIO input-capture block.
//   cap_evt_t  : one captured edge record {pin index, direction, timestamp}
//   PIN_IDX_W  : width of the pin index field
// The record layout is fixed by CAP_WIDTH / CAP_TS_W. Instances of
// gpio_input_capture must keep WIDTH and TS_W equal to these values.
package gpio_cap_pkg;

  localparam int CAP_WIDTH = 8;
  localparam int CAP_TS_W  = 16;
  localparam int PIN_IDX_W = $clog2(CAP_WIDTH);

  typedef struct packed {
    logic [PIN_IDX_W-1:0] pin;
    logic                 rising;
    logic [CAP_TS_W-1:0]  ts;
  } cap_evt_t;

endpackage

// File: rtl/cap_fifo.sv
// Synchronous show-ahead FIFO of cap_evt_t records with a valid/ready output.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_evt; accepted when not full, or when full and
//                the head is popped in the same cycle
//   push_evt   : record to write
//   full       : no free entry
//   out_valid  : head holds a record
//   out_ready  : consumer takes the head this cycle
//   out_evt    : head record, forced to zero while empty
module cap_fifo
  import gpio_cap_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  cap_evt_t push_evt,
  output logic     full,
  output logic     out_valid,
  input  logic     out_ready,
  output cap_evt_t out_evt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cap_evt_t       mem_reg [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic           do_pop;
  logic           do_push;

  assign full      = (count_reg == CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign do_pop    = out_valid & out_ready;
  // A pop frees the slot being written, so a full FIFO still takes a push.
  assign do_push   = push & (~full | do_pop);
  assign out_evt   = out_valid ? mem_reg[rd_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_input_capture.sv
// Input side of the MCU pin interface: synchronises the dedicated input pins,
// detects edges, timestamps them and queues {pin, edge, time} records.
//   clk, rst      : clock, synchronous active-high reset
//   en            : capture and timer enable
//   pins_in       : raw asynchronous pin levels
//   rise_en       : per-pin rising-edge capture enable
//   fall_en       : per-pin falling-edge capture enable
//   evt_valid     : head event available
//   evt_ready     : consumer accepts the head this cycle
//   evt_pin       : pin index of head event
//   evt_rising    : 1 = rising edge, 0 = falling edge
//   evt_time      : timer value when the edge entered its pending slot
//   level         : synchronised pin levels
//   overflow      : sticky, an edge was lost
//   overflow_clr  : clears overflow (a same-cycle set wins)
// Pipeline: sync chain -> prev/edge register -> pending slot -> FIFO, which
// gives SYNC_STAGES+2 cycles from pin sample to evt_valid.
module gpio_input_capture
  import gpio_cap_pkg::*;
#(
  parameter int WIDTH       = CAP_WIDTH,
  parameter int TS_W        = CAP_TS_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         pins_in,
  input  logic [WIDTH-1:0]         rise_en,
  input  logic [WIDTH-1:0]         fall_en,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(WIDTH)-1:0] evt_pin,
  output logic                     evt_rising,
  output logic [TS_W-1:0]          evt_time,
  output logic [WIDTH-1:0]         level,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int IDX_W   = $clog2(WIDTH);
  localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]   sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0]   sync_out;
  logic [WIDTH-1:0]   prev_reg;
  logic [WIDTH-1:0]   edge_reg;
  logic [WIDTH-1:0]   edge_rise_reg;
  logic [PRIME_W-1:0] prime_cnt_reg;
  logic               primed;
  logic [TS_W-1:0]    timer_reg;

  logic [WIDTH-1:0]   pend_vec;
  logic [WIDTH-1:0]   slot_rise_vec;
  logic [TS_W-1:0]    slot_ts [WIDTH];
  logic [WIDTH-1:0]   lost_vec;
  logic [WIDTH-1:0]   grant_oh;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_pend;
  logic               can_push;
  logic               push;
  logic               fifo_full;
  cap_evt_t           push_evt;
  cap_evt_t           head_evt;
  logic               overflow_reg;

  // Synchroniser chain, all pins in parallel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= '0;
      end
    end else begin
      sync_reg[0] <= pins_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= sync_reg[s-1];
      end
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign level    = sync_out;

  // The chain and prev hold reset zeros for the first cycles; comparing
  // against them would report a fake rising edge on pins held high through
  // reset, so edges stay masked until real samples fill both sides.
  assign primed = (prime_cnt_reg == PRIME_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg      <= '0;
      edge_reg      <= '0;
      edge_rise_reg <= '0;
      prime_cnt_reg <= '0;
    end else begin
      prev_reg      <= sync_out;
      edge_reg      <= primed ? (sync_out ^ prev_reg) : '0;
      edge_rise_reg <= sync_out;
      if (!primed) begin
        prime_cnt_reg <= prime_cnt_reg + PRIME_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_reg <= '0;
    end else if (en) begin
      timer_reg <= timer_reg + TS_W'(1);
    end
  end

  // Per-pin pending slot. A slot being pushed this cycle counts as free, so
  // an edge arriving as it drains is kept rather than lost.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_slot
      logic            pend_reg;
      logic            rise_reg;
      logic [TS_W-1:0] ts_reg;
      logic            hit;
      logic            busy;

      assign hit  = edge_reg[gi] & en &
                    (edge_rise_reg[gi] ? rise_en[gi] : fall_en[gi]);
      assign busy = pend_reg & ~grant_oh[gi];
      assign lost_vec[gi] = hit & busy;

      always_ff @(posedge clk) begin
        if (rst) begin
          pend_reg <= 1'b0;
          rise_reg <= 1'b0;
          ts_reg   <= '0;
        end else if (hit && !busy) begin
          pend_reg <= 1'b1;
          rise_reg <= edge_rise_reg[gi];
          ts_reg   <= timer_reg;
        end else if (grant_oh[gi]) begin
          pend_reg <= 1'b0;
        end
      end

      assign pend_vec[gi]      = pend_reg;
      assign slot_rise_vec[gi] = rise_reg;
      assign slot_ts[gi]       = ts_reg;
    end
  endgenerate

  // Fixed priority: lowest pending index wins (scan high to low, last hit sticks).
  always_comb begin
    any_pend  = 1'b0;
    grant_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend_vec[i]) begin
        any_pend  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

  assign can_push = ~fifo_full | (evt_valid & evt_ready);
  assign push     = any_pend & can_push;
  assign grant_oh = push ? (WIDTH'(1) << grant_idx) : '0;

  always_comb begin
    push_evt        = '0;
    push_evt.pin    = grant_idx;
    push_evt.rising = slot_rise_vec[grant_idx];
    push_evt.ts     = slot_ts[grant_idx];
  end

  cap_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_evt (push_evt),
    .full     (fifo_full),
    .out_valid(evt_valid),
    .out_ready(evt_ready),
    .out_evt  (head_evt)
  );

  assign evt_pin    = head_evt.pin;
  assign evt_rising = head_evt.rising;
  assign evt_time   = head_evt.ts;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (|lost_vec) begin
      overflow_reg <= 1'b1;
    end else if (overflow_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  assign overflow = overflow_reg;

endmodule
